// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoder definitions: opcodes, the canonical NOP, the
// instruction-format classification and the encoder FSM states.
package rv_enc_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [0:0] {
        IDLE,
        PEND_ADDI
    } enc_state_t;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_R,
        FMT_BAD
    } fmt_t;

    function automatic fmt_t opcode_fmt(input logic [6:0] op);
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_JAL:                   return FMT_J;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_REG:                   return FMT_R;
            default:                  return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle between an instruction producer and the encoder.
// The master side issues requests and consumes encoded words.
interface imm_encoder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_li;
    logic [6:0]            in_opcode;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [DATA_WIDTH-1:0] in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic                  out_err;

    modport master (
        output in_valid, in_li, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_li, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/imm_field_packer.sv
// Scatters a 32-bit immediate into its instruction-word bit positions for the
// opcode's format and reports whether the value is representable.
module imm_field_packer
    import rv_enc_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        fits
);
    logic sext12;
    logic sext13;
    logic sext21;

    // A value fits N signed bits when everything above bit N-1 copies the sign.
    assign sext12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign sext13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign sext21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        imm_bits = '0;
        fits     = 1'b0;
        case (opcode_fmt(opcode))
            FMT_I: begin
                imm_bits = {imm[11:0], 20'd0};
                fits     = sext12;
            end
            FMT_S: begin
                imm_bits = {imm[11:5], 13'd0, imm[4:0], 7'd0};
                fits     = sext12;
            end
            FMT_B: begin
                imm_bits = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
                fits     = sext13 & ~imm[0];
            end
            FMT_J: begin
                imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
                fits     = sext21 & ~imm[0];
            end
            FMT_U: begin
                imm_bits = {imm[31:12], 12'd0};
                fits     = (imm[11:0] == 12'd0);
            end
            FMT_R: begin
                fits = 1'b1;
            end
            default: begin
                fits = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/imm_encoder.sv
// Streaming RV32I encoder: packs fields plus immediate into one instruction
// word per request, expanding LI into LUI/ADDI when one word is not enough.
module imm_encoder
    import rv_enc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    imm_encoder_if.slave bus,
    output logic [15:0]  enc_count
);
    enc_state_t            state_reg;
    logic                  out_valid_reg;
    logic                  out_err_reg;
    logic [DATA_WIDTH-1:0] out_instr_reg;
    logic [15:0]           enc_count_reg;
    logic [4:0]            pend_rd_reg;
    logic [11:0]           pend_lo_reg;

    logic [31:0] imm_bits;
    logic        fits;
    logic [31:0] field_bits;
    logic [31:0] enc_word;
    logic [31:0] li_word;
    logic [31:0] word_next;
    logic        err_next;
    logic        li_fits12;
    logic        li_two;
    logic [19:0] li_hi;
    logic        in_accept;
    logic        out_hs;

    imm_field_packer u_packer (
        .opcode   (bus.in_opcode),
        .imm      (bus.in_imm),
        .imm_bits (imm_bits),
        .fits     (fits)
    );

    always_comb begin
        field_bits = '0;
        case (opcode_fmt(bus.in_opcode))
            FMT_I:        field_bits = {12'd0, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_S, FMT_B: field_bits = {7'd0, bus.in_rs2, bus.in_rs1, bus.in_funct3, 5'd0, bus.in_opcode};
            FMT_J, FMT_U: field_bits = {20'd0, bus.in_rd, bus.in_opcode};
            FMT_R:        field_bits = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                        bus.in_rd, bus.in_opcode};
            default:      field_bits = '0;
        endcase
    end

    assign enc_word = fits ? (field_bits | imm_bits) : NOP_INSTR;

    // Rounding the upper part by imm[11] lets the trailing ADDI add a signed lo.
    assign li_fits12 = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
    assign li_hi     = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};
    assign li_two    = !li_fits12 && (bus.in_imm[11:0] != 12'd0);
    assign li_word   = li_fits12 ? {bus.in_imm[11:0], 5'd0, 3'b000, bus.in_rd, OP_IMM}
                                 : {li_hi, bus.in_rd, OP_LUI};

    assign word_next = bus.in_li ? li_word : enc_word;
    assign err_next  = bus.in_li ? 1'b0 : !fits;

    assign bus.in_ready  = (state_reg == IDLE) && (!out_valid_reg || bus.out_ready);
    assign in_accept     = bus.in_valid && bus.in_ready;
    assign out_hs        = out_valid_reg && bus.out_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_instr = out_instr_reg;
    assign bus.out_err   = out_err_reg;
    assign enc_count     = enc_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_instr_reg <= '0;
            out_err_reg   <= 1'b0;
            enc_count_reg <= 16'd0;
            pend_rd_reg   <= 5'd0;
            pend_lo_reg   <= 12'd0;
        end else begin
            if (out_hs) begin
                enc_count_reg <= enc_count_reg + 16'd1;
            end
            case (state_reg)
                IDLE: begin
                    if (in_accept) begin
                        out_valid_reg <= 1'b1;
                        out_instr_reg <= word_next;
                        out_err_reg   <= err_next;
                        if (bus.in_li && li_two) begin
                            state_reg   <= PEND_ADDI;
                            pend_rd_reg <= bus.in_rd;
                            pend_lo_reg <= bus.in_imm[11:0];
                        end
                    end else if (out_hs) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                PEND_ADDI: begin
                    // LUI word is leaving; its ADDI follower replaces it on the same edge.
                    if (out_hs) begin
                        out_instr_reg <= {pend_lo_reg, pend_rd_reg, 3'b000, pend_rd_reg, OP_IMM};
                        out_err_reg   <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Directed plus randomized bench for imm_encoder, scored against a queue of
// expected words built from the RV32I encoding rules with plain arithmetic.
module tb_imm_encoder;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] enc_count;

    imm_encoder_if #(.DATA_WIDTH(32)) ifc ();

    imm_encoder #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (ifc),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [15:0] model_count = 16'd0;
    int          checks = 0;
    int          passes = 0;
    bit          rand_ready = 1'b0;

    bit [6:0]  ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F, 7'h0B};
    bit [31:0] bnd [13] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4096,
                            32'hFFFFF000, 32'd1048574, 32'd1048576, 32'hFFF00000, 32'h7FFFF800,
                            32'h80000000, 32'd0};

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic push_word(input logic [31:0] w, input logic e);
        exp_t x;
        x.instr = w;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Reference encoder: range checks on the signed value, fields placed by shifts.
    task automatic model_push(input bit li, input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                              input bit [4:0] rs2, input bit [2:0] f3, input bit [6:0] f7,
                              input bit [31:0] imm);
        longint   v    = longint'($signed(imm));
        bit [31:0] r_d  = 32'(rd) << 7;
        bit [31:0] r_s1 = 32'(rs1) << 15;
        bit [31:0] r_s2 = 32'(rs2) << 20;
        bit [31:0] f_3  = 32'(f3) << 12;
        bit [31:0] f_7  = 32'(f7) << 25;
        bit [31:0] o    = 32'(op);
        bit [31:0] w    = 32'd0;
        bit        ok   = 1'b0;
        longint    lo;
        longint    hi;
        if (li) begin
            if (v >= -2048 && v <= 2047) begin
                push_word(((imm & 32'hFFF) << 20) | r_d | 32'h13, 1'b0);
            end else begin
                lo = longint'(imm & 32'hFFF);
                if (lo >= 2048) lo = lo - 4096;
                hi = ((v - lo) >>> 12) & 64'hFFFFF;
                push_word((32'(hi) << 12) | r_d | 32'h37, 1'b0);
                if (lo != 0)
                    push_word((32'(lo & 64'hFFF) << 20) | (32'(rd) << 15) | r_d | 32'h13, 1'b0);
            end
        end else begin
            case (op)
                7'h13, 7'h03, 7'h67: begin
                    ok = (v >= -2048 && v <= 2047);
                    w  = ((imm & 32'hFFF) << 20) | r_s1 | f_3 | r_d | o;
                end
                7'h23: begin
                    ok = (v >= -2048 && v <= 2047);
                    w  = (((imm >> 5) & 32'h7F) << 25) | r_s2 | r_s1 | f_3 | ((imm & 32'h1F) << 7) | o;
                end
                7'h63: begin
                    ok = (v >= -4096 && v <= 4094 && imm[0] == 1'b0);
                    w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r_s2 | r_s1 | f_3
                       | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | o;
                end
                7'h6F: begin
                    ok = (v >= -1048576 && v <= 1048574 && imm[0] == 1'b0);
                    w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                       | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | r_d | o;
                end
                7'h37, 7'h17: begin
                    ok = ((imm & 32'hFFF) == 32'd0);
                    w  = (imm & 32'hFFFFF000) | r_d | o;
                end
                7'h33: begin
                    ok = 1'b1;
                    w  = f_7 | r_s2 | r_s1 | f_3 | r_d | o;
                end
                default: ok = 1'b0;
            endcase
            if (ok) push_word(w, 1'b0);
            else    push_word(32'h00000013, 1'b1);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return at posedge+1.
    task automatic tick(output bit acc);
        bit exp_ready;
        if (rand_ready) ifc.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && ifc.out_ready);
        check1("out_valid", ifc.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check32("out_instr", ifc.out_instr, exp_q[0].instr);
            check1("out_err", ifc.out_err, exp_q[0].err);
        end
        check32("enc_count", {16'd0, enc_count}, {16'd0, model_count});
        check1("in_ready", ifc.in_ready, exp_ready);
        acc = ifc.in_valid && exp_ready && !reset;
        if (exp_q.size() != 0 && ifc.out_ready && !reset) begin
            void'(exp_q.pop_front());
            model_count++;
        end
        if (acc) model_push(ifc.in_li, ifc.in_opcode, ifc.in_rd, ifc.in_rs1, ifc.in_rs2,
                            ifc.in_funct3, ifc.in_funct7, ifc.in_imm);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit li, input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                        input bit [4:0] rs2, input bit [2:0] f3, input bit [6:0] f7,
                        input bit [31:0] imm, output int waited);
        bit acc = 1'b0;
        ifc.in_li     = li;
        ifc.in_opcode = op;
        ifc.in_rd     = rd;
        ifc.in_rs1    = rs1;
        ifc.in_rs2    = rs2;
        ifc.in_funct3 = f3;
        ifc.in_funct7 = f7;
        ifc.in_imm    = imm;
        ifc.in_valid  = 1'b1;
        waited = 0;
        do begin
            tick(acc);
            waited++;
        end while (!acc && waited < 50);
        ifc.in_valid = 1'b0;
        ifc.in_imm   = $urandom();
        ifc.in_rd    = 5'($urandom());
        check1("send_accept", acc, 1'b1);
        $display("req li=%0d op=%02h imm=%08h accepted after %0d cycle(s)", li, op, imm, waited);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(acc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          waited;
        logic [15:0] cnt0;
        bit [6:0]    op;
        bit [31:0]   imm;

        ifc.in_valid = 1'b0; ifc.in_li = 1'b0; ifc.in_opcode = 7'd0; ifc.in_rd = 5'd0;
        ifc.in_rs1 = 5'd0; ifc.in_rs2 = 5'd0; ifc.in_funct3 = 3'd0; ifc.in_funct7 = 7'd0;
        ifc.in_imm = 32'd0; ifc.out_ready = 1'b1;

        @(posedge clk);
        #1;
        check1("rst_out_valid", ifc.out_valid, 1'b0);
        check32("rst_out_instr", ifc.out_instr, 32'h0);
        check1("rst_out_err", ifc.out_err, 1'b0);
        check32("rst_enc_count", {16'd0, enc_count}, 32'h0);
        check1("rst_in_ready", ifc.in_ready, 1'b1);
        reset = 1'b0;

        // ADDI x1, x2, -1 and BEQ x1, x2, +8 / +3
        send(1'b0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, waited);
        check32("addi_word", ifc.out_instr, 32'hFFF10093);
        check1("addi_err", ifc.out_err, 1'b0);
        send(1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, waited);
        check32("beq_word", ifc.out_instr, 32'h00208463);
        send(1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, waited);
        check32("beq_odd_word", ifc.out_instr, 32'h00000013);
        check1("beq_odd_err", ifc.out_err, 1'b1);
        drain();

        // LI expansions
        cnt0 = model_count;
        send(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, waited);
        check32("li_lui", ifc.out_instr, 32'h123462B7);
        check1("li_in_ready", ifc.in_ready, 1'b0);
        tick(acc);
        check32("li_addi", ifc.out_instr, 32'hFFF28293);
        tick(acc);
        check32("li_count", {16'd0, enc_count}, {16'd0, cnt0 + 16'd2});
        send(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00002000, waited);
        check32("li_lui_only", ifc.out_instr, 32'h000022B7);
        tick(acc);
        send(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7FFFF800, waited);
        check32("li_lui_top", ifc.out_instr, 32'h800002B7);
        tick(acc);
        check32("li_addi_neg", ifc.out_instr, 32'h80028293);
        drain();

        // Back-pressure, then back-to-back acceptance on release
        ifc.out_ready = 1'b0;
        send(1'b0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, waited);
        repeat (3) tick(acc);
        ifc.out_ready = 1'b1;
        send(1'b0, 7'h23, 5'd0, 5'd8, 5'd9, 3'd2, 7'd0, 32'hFFFFF801, waited);
        check32("b2b_wait", 32'(waited), 32'd1);
        drain();

        // Reset while the ADDI half of an LI is pending
        ifc.out_ready = 1'b0;
        send(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, waited);
        tick(acc);
        reset = 1'b1;
        #1;
        check1("midrst_valid", ifc.out_valid, 1'b0);
        exp_q.delete();
        model_count = 16'd0;
        tick(acc);
        reset = 1'b0;
        ifc.out_ready = 1'b1;
        send(1'b0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, waited);
        check32("postrst_word", ifc.out_instr, 32'hFFF10093);
        drain();

        // Counter wrap
        force dut.enc_count_reg = 16'hFFFF;
        #1;
        release dut.enc_count_reg;
        model_count = 16'hFFFF;
        send(1'b0, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, waited);
        tick(acc);
        check32("count_wrap", {16'd0, enc_count}, 32'h0);

        // Randomized traffic with random output back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 10)];
            case ($urandom_range(0, 4))
                0:       imm = $urandom_range(0, 6000) - 3000;
                1:       imm = $urandom() & 32'hFFFFF000;
                2:       imm = bnd[$urandom_range(0, 12)];
                3:       imm = ($urandom_range(0, 4194303) - 2097152) & 32'hFFFFFFFE;
                default: imm = $urandom();
            endcase
            send($urandom_range(0, 4) == 0, op, 5'($urandom()), 5'($urandom()), 5'($urandom()),
                 3'($urandom()), 7'($urandom()), imm, waited);
            if ($urandom_range(0, 3) == 0) tick(acc);
        end
        rand_ready = 1'b0;
        ifc.out_ready = 1'b1;
        drain();
        tick(acc);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
